// File: rtl/tile_desc_if.sv
// tile_desc_if: descriptor valid/ready bus between the tile sequencer and its AGU/DMA consumers
interface tile_desc_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = 8
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] a, b, c;
    logic [IDX_WIDTH-1:0]  etm, etn, etk;
    logic                  first_k, last_k, last;
    modport master (output valid, a, b, c, etm, etn, etk, first_k, last_k, last, input ready);
    modport slave  (input valid, a, b, c, etm, etn, etk, first_k, last_k, last, output ready);
endinterface

// File: rtl/tile_desc_sequencer.sv
// tile_desc_sequencer: walks an M x N x K GEMM in tiles, one registered descriptor per handshake; TILE_SEQ_PERF_EN adds perf counters
module tile_desc_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  loop_order,
    input  logic [IDX_WIDTH-1:0]  M, N, K, TM, TN, TK,
    input  logic [ADDR_WIDTH-1:0] lda, ldb, ldc,
    input  logic [ADDR_WIDTH-1:0] baseA, baseB, baseC,
    tile_desc_if.master           desc,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
`ifdef TILE_SEQ_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  tile_count,
    output logic [CNT_WIDTH-1:0]  stall_cycles
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
    state_t state, state_nxt;
    logic order;
    logic [IDX_WIDTH-1:0] dm, dn, dk, tm, tn, tk;
    logic [ADDR_WIDTH-1:0] st_a, st_b, st_c, ba, bb, bc;
    logic [ADDR_WIDTH-1:0] s_am, s_bk, s_cm;
    logic [IDX_WIDTH-1:0] rm, rn, rk;
    logic [ADDR_WIDTH-1:0] o_am, o_ak, o_bk, o_n, o_cm;
    logic bad, accept, reject, hs, load, adv;
    logic lk, lm, ln, clr_k, step_n, clr_n, step_m, clr_m;
    logic [IDX_WIDTH-1:0] rm_n, rn_n, rk_n;
    logic [ADDR_WIDTH-1:0] o_am_n, o_ak_n, o_bk_n, o_n_n, o_cm_n;

    assign bad    = !(|M && |N && |K && |TM && |TN && |TK);
    assign accept = state == IDLE && start && !abort && !bad;
    assign reject = state == IDLE && start && !abort && bad;
    assign hs     = state == EMIT && desc.ready && !abort;
    assign load   = state == LOAD;
    assign adv    = load || (hs && !desc.last);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    // next state and status outputs; abort wins over every transition
    always_comb begin
        state_nxt  = state;
        busy       = state == LOAD || state == EMIT;
        done       = state == DONE;
        desc.valid = state == EMIT;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: state_nxt = EMIT;
            EMIT: if (hs && desc.last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // next tile: k innermost, middle/outer chosen by loop order; remaining counts and offsets step by add only
    always_comb begin
        lk     = rk <= tk;
        lm     = rm <= tm;
        ln     = rn <= tn;
        clr_k  = load || lk;
        step_n = lk && (order ? lm : !ln);
        clr_n  = load || (lk && !order && ln);
        step_m = lk && (order ? !lm : ln);
        clr_m  = load || (lk && order && lm);
        rk_n   = clr_k ? dk : rk - tk;
        o_ak_n = clr_k ? '0 : o_ak + ADDR_WIDTH'(tk);
        o_bk_n = clr_k ? '0 : o_bk + s_bk;
        rn_n   = clr_n ? dn : step_n ? rn - tn : rn;
        o_n_n  = clr_n ? '0 : step_n ? o_n + ADDR_WIDTH'(tn) : o_n;
        rm_n   = clr_m ? dm : step_m ? rm - tm : rm;
        o_am_n = clr_m ? '0 : step_m ? o_am + s_am : o_am;
        o_cm_n = clr_m ? '0 : step_m ? o_cm + s_cm : o_cm;
    end

    // config latch on accepted start, stride products in LOAD, descriptor registers on advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order <= 1'b0;
            {dm, dn, dk, tm, tn, tk} <= '0;
            {st_a, st_b, st_c, ba, bb, bc} <= '0;
            {s_am, s_bk, s_cm} <= '0;
            {rm, rn, rk} <= '0;
            {o_am, o_ak, o_bk, o_n, o_cm} <= '0;
            {desc.a, desc.b, desc.c} <= '0;
            {desc.etm, desc.etn, desc.etk} <= '0;
            {desc.first_k, desc.last_k, desc.last} <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= reject;
            if (accept) begin
                order <= loop_order;
                {dm, dn, dk, tm, tn, tk} <= {M, N, K, TM, TN, TK};
                {st_a, st_b, st_c, ba, bb, bc} <= {lda, ldb, ldc, baseA, baseB, baseC};
            end
            if (load) begin
                s_am <= ADDR_WIDTH'(tm) * st_a;
                s_bk <= ADDR_WIDTH'(tk) * st_b;
                s_cm <= ADDR_WIDTH'(tm) * st_c;
            end
            if (adv) begin
                {rm, rn, rk} <= {rm_n, rn_n, rk_n};
                {o_am, o_ak, o_bk, o_n, o_cm} <= {o_am_n, o_ak_n, o_bk_n, o_n_n, o_cm_n};
                desc.a       <= ba + o_am_n + o_ak_n;
                desc.b       <= bb + o_bk_n + o_n_n;
                desc.c       <= bc + o_cm_n + o_n_n;
                desc.etm     <= rm_n < tm ? rm_n : tm;
                desc.etn     <= rn_n < tn ? rn_n : tn;
                desc.etk     <= rk_n < tk ? rk_n : tk;
                desc.first_k <= clr_k;
                desc.last_k  <= rk_n <= tk;
                desc.last    <= rm_n <= tm && rn_n <= tn && rk_n <= tk;
            end
        end
    end

`ifdef TILE_SEQ_PERF_EN
    // saturating handshake and stall counters, cleared on accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_count   <= '0;
            stall_cycles <= '0;
        end else if (accept) begin
            tile_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (hs && tile_count != '1) tile_count <= tile_count + 1'b1;
            if (desc.valid && !desc.ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_tile_desc_sequencer.sv
// tb_tile_desc_sequencer: directed bench for the tile descriptor sequencer
module tb_tile_desc_sequencer;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, loop_order = 1'b0;
    logic [7:0] M = '0, N = '0, K = '0, TM = '0, TN = '0, TK = '0;
    logic [31:0] lda = '0, ldb = '0, ldc = '0;
    logic [31:0] baseA = 32'h1000, baseB = 32'h2000, baseC = 32'h3000;
    logic busy, done, cfg_err;
`ifdef TILE_SEQ_PERF_EN
    logic [15:0] tile_count, stall_cycles;
`endif
    int vecs = 0, errs = 0, nexp = 0, stalls = 0;
    logic [31:0] ea[32], eb[32], ec[32];
    logic [7:0]  em[32], en[32], ek[32];
    logic [2:0]  ef[32];

    tile_desc_if #(.ADDR_WIDTH(32), .IDX_WIDTH(8)) desc ();

    tile_desc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_order(loop_order),
        .M(M), .N(N), .K(K), .TM(TM), .TN(TN), .TK(TK),
        .lda(lda), .ldb(ldb), .ldc(ldc), .baseA(baseA), .baseB(baseB), .baseC(baseC),
        .desc(desc), .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef TILE_SEQ_PERF_EN
        , .tile_count(tile_count), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected descriptor list from the closed-form addresses (direct multiplies)
    task automatic build(input int dm, dn, dk, tm, tn, tk, la, lb, lc, input logic ord);
        int nm, nn, nk, mi, ni;
        nm = (dm + tm - 1) / tm;
        nn = (dn + tn - 1) / tn;
        nk = (dk + tk - 1) / tk;
        nexp = 0;
        for (int o = 0; o < (ord ? nn : nm); o++)
            for (int i = 0; i < (ord ? nm : nn); i++)
                for (int k = 0; k < nk; k++) begin
                    mi = ord ? i : o;
                    ni = ord ? o : i;
                    ea[nexp] = 32'(32'h1000 + mi * tm * la + k * tk);
                    eb[nexp] = 32'(32'h2000 + k * tk * lb + ni * tn);
                    ec[nexp] = 32'(32'h3000 + mi * tm * lc + ni * tn);
                    em[nexp] = 8'((dm - mi * tm) < tm ? dm - mi * tm : tm);
                    en[nexp] = 8'((dn - ni * tn) < tn ? dn - ni * tn : tn);
                    ek[nexp] = 8'((dk - k * tk) < tk ? dk - k * tk : tk);
                    ef[nexp] = {k == 0, k == nk - 1, mi == nm - 1 && ni == nn - 1 && k == nk - 1};
                    nexp++;
                end
    endtask

    // pulse start with the given config, then scramble config to prove it was latched; ends in the LOAD cycle
    task automatic job(input int dm, dn, dk, tm, tn, tk, la, lb, lc, input logic ord);
        build(dm, dn, dk, tm, tn, tk, la, lb, lc, ord);
        @(negedge clk);
        {M, N, K, TM, TN, TK} = {8'(dm), 8'(dn), 8'(dk), 8'(tm), 8'(tn), 8'(tk)};
        {lda, ldb, ldc} = {32'(la), 32'(lb), 32'(lc)};
        loop_order = ord;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        M = 8'd1;
        lda = 32'd0;
        loop_order = ~ord;
        chk("load_valid", {63'd0, desc.valid}, 64'd0);
        chk("load_busy", {63'd0, busy}, 64'd1);
    endtask

    // consume the whole job, comparing each handshake against the expected list
    task automatic walk(input logic rnd);
        int idx, cyc;
        logic [31:0] pa, pb, pc;
        logic stalled;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        stalls = 0;
        while (idx < nexp && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                chk("stall_a", 64'(desc.a), 64'(pa));
                chk("stall_b", 64'(desc.b), 64'(pb));
                chk("stall_c", 64'(desc.c), 64'(pc));
            end
            desc.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = desc.valid && !desc.ready;
            if (stalled) begin
                stalls++;
                pa = desc.a;
                pb = desc.b;
                pc = desc.c;
            end
            if (desc.valid && desc.ready) begin
                chk($sformatf("a#%0d", idx), 64'(desc.a), 64'(ea[idx]));
                chk($sformatf("b#%0d", idx), 64'(desc.b), 64'(eb[idx]));
                chk($sformatf("c#%0d", idx), 64'(desc.c), 64'(ec[idx]));
                chk($sformatf("et#%0d", idx), 64'({desc.etm, desc.etn, desc.etk}), 64'({em[idx], en[idx], ek[idx]}));
                chk($sformatf("flags#%0d", idx), 64'({desc.first_k, desc.last_k, desc.last}), 64'(ef[idx]));
                idx++;
            end
        end
        chk("handshakes", 64'(idx), 64'(nexp));
        if (!rnd) chk("cycles", 64'(cyc), 64'(nexp));
        @(negedge clk);
        desc.ready = 1'b0;
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("valid_off", {63'd0, desc.valid}, 64'd0);
        @(negedge clk);
        chk("done_clear", {63'd0, done}, 64'd0);
        chk("busy_off", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        desc.ready = 1'b0;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_status", {61'd0, busy, done, cfg_err}, 64'd0);
        chk("rst_valid", {63'd0, desc.valid}, 64'd0);
        chk("rst_a", 64'(desc.a), 64'd0);
        chk("rst_flags", 64'({desc.etm, desc.first_k, desc.last_k, desc.last}), 64'd0);
        rst = 1'b0;
        // T1 basic walk, full throughput
        job(8, 8, 8, 4, 4, 4, 8, 8, 8, 1'b0);
        walk(1'b0);
        // T2 ragged edges, distinct strides
        job(10, 6, 5, 4, 4, 4, 16, 12, 20, 1'b0);
        walk(1'b0);
        // T3 n-outer loop order (#2 has c = 0x3020)
        job(8, 8, 8, 4, 4, 4, 8, 8, 8, 1'b1);
        walk(1'b0);
        // T4 random backpressure
        job(8, 8, 8, 4, 4, 4, 8, 8, 8, 1'b0);
        walk(1'b1);
`ifdef TILE_SEQ_PERF_EN
        chk("tile_count", 64'(tile_count), 64'd8);
        chk("stall_cycles", 64'(stall_cycles), 64'(stalls));
`endif
        // T5 abort together with handshake #3
        job(8, 8, 8, 4, 4, 4, 8, 8, 8, 1'b0);
        desc.ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_abort_a", 64'(desc.a), 64'h1004);
        chk("pre_abort_b", 64'(desc.b), 64'h2024);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        desc.ready = 1'b0;
        chk("abort_status", {61'd0, busy, done, desc.valid}, 64'd0);
        @(negedge clk);
        chk("abort_no_done", {63'd0, done}, 64'd0);
        job(8, 8, 8, 4, 4, 4, 8, 8, 8, 1'b0);
        walk(1'b0);
        // start while busy is ignored, then rst mid-job
        job(8, 8, 8, 4, 4, 4, 8, 8, 8, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_valid", {63'd0, desc.valid}, 64'd1);
        chk("busy_start_a", 64'(desc.a), 64'h1000);
        desc.ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_status", {61'd0, busy, done, desc.valid}, 64'd0);
        chk("mid_rst_addr", 64'(desc.b), 64'd0);
        chk("mid_rst_flags", 64'({desc.etk, desc.first_k, desc.last_k, desc.last}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        desc.ready = 1'b0;
        // T6 zero tile dim rejected
        @(negedge clk);
        {M, N, K, TM, TN, TK} = {8'd8, 8'd8, 8'd8, 8'd4, 8'd4, 8'd0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_pulse", {63'd0, cfg_err}, 64'd1);
        chk("cfg_err_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("cfg_err_clear", {62'd0, cfg_err, busy}, 64'd0);
        // T6 single-tile job
        job(3, 3, 3, 4, 4, 4, 8, 8, 8, 1'b0);
        walk(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
